// File: rtl/bin_iir_smoother.sv
// bin_iir_smoother: per-bin first-order IIR (exponential moving average)
// smoother for the DFT magnitude array. One bin is updated per clock, serially:
//   y += (x - y) >>> shift
// Build option: define BIN_IIR_PEAK_HOLD_EN for fast attack / slow decay
// (a rising input is copied straight through, a falling one decays normally).
module bin_iir_smoother #(
   parameter int BINS = 120,
   parameter int ND   = 36,
   parameter int KW   = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ND-1:0]           inBins [0:BINS-1],
   input  logic                    start,
   input  logic [KW-1:0]           shift,
   output logic [ND-1:0]           outBins [0:BINS-1],
   output logic                    busy,
   output logic                    done,
   output logic [$clog2(BINS)-1:0] binIndex,
   output logic                    overrun
);

   localparam int            IW       = $clog2(BINS);
   localparam int            SW       = $clog2(ND + 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(BINS - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t             state;
   state_t             next_state;
   logic [IW-1:0]      idx;
   logic [SW-1:0]      shift_reg;
   logic [SW-1:0]      shift_clamped;
   logic [ND-1:0]      x;
   logic [ND-1:0]      y;
   logic [ND-1:0]      new_y;
   logic signed [ND:0] d;
   logic signed [ND:0] step;

   // Clamp the requested shift to ND; any larger shift behaves the same anyway.
   always_comb begin
      if (int'(shift) > ND) shift_clamped = SW'(ND);
      else                  shift_clamped = SW'(shift);
   end

   // Single subtract / arithmetic-shift / add datapath for the current bin.
   // NOTE: combinational blocks use blocking '=' so later lines see earlier results;
   // clocked blocks use '<=' so all flops update together at the edge.
   always_comb begin
      x     = inBins[idx];
      y     = outBins[idx];
      d     = $signed({1'b0, x}) - $signed({1'b0, y});
      step  = d >>> shift_reg;
      // Result always lies between y and x, so dropping the top bit cannot overflow.
      new_y = ND'({1'b0, y} + step);
`ifdef BIN_IIR_PEAK_HOLD_EN
      if (x > y) new_y = x;
`endif
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state logic: IDLE -> RUN on start, RUN until the last bin, FIN for one cycle.
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = RUN;
         RUN:     if (idx == LAST_IDX) next_state = FIN;
         FIN:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Datapath registers: bin index, latched shift, smoothed bins, sticky overrun.
   // NOTE: outBins is a flop array (not RAM), so reset clears it like any other state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx       <= '0;
         shift_reg <= '0;
         overrun   <= 1'b0;
         for (int i = 0; i < BINS; i++) outBins[i] <= '0;
      end else begin
         if (start && (state != IDLE)) overrun <= 1'b1;
         case (state)
            IDLE: begin
               if (start) begin
                  idx       <= '0;
                  shift_reg <= shift_clamped;
               end
            end
            RUN: begin
               outBins[idx] <= new_y;
               idx          <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Status outputs decoded from the state.
   always_comb begin
      busy     = (state == RUN);
      done     = (state == FIN);
      binIndex = busy ? idx : '0;
   end

endmodule

// File: tb/tb_bin_iir_smoother.sv
// tb_bin_iir_smoother: directed bench for bin_iir_smoother. Expected bin values
// are pushed to a scoreboard queue when a pass is launched and popped as each
// bin is written. Honours BIN_IIR_PEAK_HOLD_EN in the same way as the design.
module tb_bin_iir_smoother;

   localparam int BINS = 120;
   localparam int ND   = 36;
   localparam int KW   = 6;
   localparam int IW   = $clog2(BINS);

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic          start = 1'b0;
   logic [KW-1:0] shift = '0;
   logic [ND-1:0] in_bins  [0:BINS-1];
   logic [ND-1:0] out_bins [0:BINS-1];
   logic          busy;
   logic          done;
   logic          overrun;
   logic [IW-1:0] bin_index;

   typedef struct {
      int            bin;
      logic [ND-1:0] val;
   } exp_t;

   exp_t   sb [$];
   longint model [0:BINS-1];
   int     n_cmp = 0;
   int     n_bad = 0;

   always #5 clk = ~clk;

   bin_iir_smoother #(.BINS(BINS), .ND(ND), .KW(KW)) dut (
      .clk      (clk),
      .rst      (rst),
      .inBins   (in_bins),
      .start    (start),
      .shift    (shift),
      .outBins  (out_bins),
      .busy     (busy),
      .done     (done),
      .binIndex (bin_index),
      .overrun  (overrun)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference update for one bin: floor-shifted EMA step, shift clamped to ND.
   function automatic longint model_step(input longint y, input longint x, input int s);
      int     se = (s > ND) ? ND : s;
      longint d  = x - y;
`ifdef BIN_IIR_PEAK_HOLD_EN
      if (x > y) return x;
`endif
      return y + (d >>> se);
   endfunction

   task automatic set_all(input longint v);
      for (int i = 0; i < BINS; i++) in_bins[i] = ND'(v);
   endtask

   task automatic do_reset();
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < BINS; i++) model[i] = 0;
   endtask

   // One smoothing pass. ovr_at: cycle carrying a stray start (0 = none).
   // abort_at: cycle in which reset is asserted mid-clock (0 = none).
   task automatic run_pass(input int s, input int ovr_at, input int abort_at);
      exp_t e;
      for (int i = 0; i < BINS; i++) begin
         model[i] = model_step(model[i], longint'(in_bins[i]), s);
         sb.push_back('{bin: i, val: ND'(model[i])});
      end
      @(negedge clk);
      start = 1'b1;
      shift = KW'(s);
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= BINS; k++) begin
         @(negedge clk);
         check("busy_run", busy, 1);
         check("bin_index", bin_index, k - 1);
         check("done_run", done, 0);
         if (k == abort_at) begin
            #2 rst = 1'b1;
            #1;
            check("abort_busy", busy, 0);
            check("abort_index", bin_index, 0);
            check("abort_done", done, 0);
            for (int i = 0; i < BINS; i++) check("abort_bin", out_bins[i], 0);
            sb.delete();
            for (int i = 0; i < BINS; i++) model[i] = 0;
            for (int j = 0; j < 3; j++) begin
               @(negedge clk);
               check("abort_no_done", done, 0);
            end
            rst = 1'b0;
            return;
         end
         if (k == ovr_at) start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
         e = sb.pop_front();
         check("bin_value", out_bins[e.bin], e.val);
      end
      @(negedge clk);
      check("done_fin", done, 1);
      check("busy_fin", busy, 0);
      check("index_fin", bin_index, 0);
      @(negedge clk);
      check("done_clear", done, 0);
   endtask

   initial begin
      set_all(0);
      for (int i = 0; i < BINS; i++) model[i] = 0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_index", bin_index, 0);
      check("rst_overrun", overrun, 0);
      check("rst_bin0", out_bins[0], 0);
      check("rst_bin119", out_bins[BINS-1], 0);
      rst = 1'b0;

      // Pass-through with shift 0 and a per-bin ramp
      for (int i = 0; i < BINS; i++) in_bins[i] = ND'(100 * i);
      run_pass(0, 0, 0);
      check("t1_bin5", out_bins[5], 500);
      check("t1_bin119", out_bins[BINS-1], 11900);
      check("t1_overrun", overrun, 0);

      // Rising step, shift 2, three passes
      do_reset();
      set_all(1000);
      run_pass(2, 0, 0);
      check("t2_p1", out_bins[0], 250);
      run_pass(2, 0, 0);
      check("t2_p2", out_bins[60], 437);
      run_pass(2, 0, 0);
      check("t2_p3", out_bins[BINS-1], 577);

      // Falling step, and floor rounding of a -1 difference
      set_all(1000);
      run_pass(0, 0, 0);
      set_all(0);
      run_pass(2, 0, 0);
      check("t3_fall", out_bins[10], 750);
      set_all(1);
      run_pass(0, 0, 0);
      set_all(0);
      run_pass(3, 0, 0);
      check("t3_floor", out_bins[10], 0);

      // Oversized shift clamps to ND: a falling difference still moves by -1
      set_all(1000);
      run_pass(0, 0, 0);
      set_all(0);
      run_pass(63, 0, 0);
      check("clamp_fall", out_bins[33], 999);

      // Rise then fall with shift 4 (peak-hold build differs on the rise)
      set_all(100);
      run_pass(0, 0, 0);
      set_all(500);
      run_pass(4, 0, 0);
`ifdef BIN_IIR_PEAK_HOLD_EN
      check("t6_rise", out_bins[2], 500);
`else
      check("t6_rise", out_bins[2], 125);
`endif
      set_all(0);
      run_pass(4, 0, 0);
`ifdef BIN_IIR_PEAK_HOLD_EN
      check("t6_fall", out_bins[2], 468);
`else
      check("t6_fall", out_bins[2], 117);
`endif

      // Stray start mid-pass: ignored, overrun goes sticky
      check("t4_overrun_pre", overrun, 0);
      for (int i = 0; i < BINS; i++) in_bins[i] = ND'(37 * i + 5);
      run_pass(1, 50, 0);
      check("t4_overrun_set", overrun, 1);
      run_pass(1, 0, 0);
      check("t4_overrun_hold", overrun, 1);

      // Asynchronous reset mid-pass, then a clean full pass
      run_pass(0, 0, 60);
      check("t5_overrun_clr", overrun, 0);
      for (int i = 0; i < BINS; i++) in_bins[i] = ND'(100 * i + 7);
      run_pass(0, 0, 0);
      check("t5_bin3", out_bins[3], 307);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bin_iir_smoother.md
Name: bin_iir_smoother

Overview:
- Downstream of the DFT block. Consumes its per-bin magnitude array (BPO*OC bins) and produces a temporally smoothed copy.
- Uses a first-order IIR (exponential moving average) per bin: y += (x - y) >>> shift.
- Processes one bin per clock, serially, after each DFT sample-processing pass. This keeps the datapath to a single subtract/shift/add.
- Output feeds the downstream peak/note-finding logic.

Parameters:
BINS  120  total bin count (BPO*OC)
ND  36  magnitude width, equal to the DFT output width
KW  6  width of the shift-control input

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
inBins  input  ND x BINS (unpacked [0:BINS-1])  unsigned raw magnitudes from the DFT
start  input  1  single-cycle pulse: begin one smoothing pass
shift  input  KW  decay shift amount; sampled only on an accepted start
outBins  output  ND x BINS (unpacked [0:BINS-1])  unsigned smoothed magnitudes
busy  output  1  high while a pass is in progress
done  output  1  single-cycle pulse on pass completion
binIndex  output  $clog2(BINS)  bin being updated; 0 when not busy
overrun  output  1  sticky flag: a start arrived while not IDLE

Behaviour:
- Reset is asynchronous and active-high. It forces:
  - state IDLE, idx 0, shiftReg 0;
  - outBins all 0, busy 0, done 0, binIndex 0, overrun 0.
- Reset asserted mid-pass aborts immediately; no partial result is retained.
- State machine:
  - IDLE -> RUN on start=1: latch shiftReg = min(shift, ND), set idx = 0.
  - RUN: each cycle update bin idx, then increment idx. On idx == BINS-1, update that bin and go to FIN.
  - FIN: done = 1 for exactly one cycle, then return to IDLE.
- Timing (start sampled at edge 0):
  - busy = 1 on cycles 1..BINS;
  - bin i is written at the end of cycle i+1;
  - done = 1 on cycle BINS+1, with busy = 0 in that cycle.
  - The earliest following start is accepted in cycle BINS+2 (back in IDLE).
- start outside IDLE (RUN or FIN):
  - ignored; the pass continues unaffected;
  - sets overrun = 1, which holds until reset.
- Update arithmetic for bin i:
  - d = signed'({1'b0, inBins[i]}) - signed'({1'b0, outBins[i]}), ND+1 bits;
  - outBins[i] <= outBins[i] + (d >>> shiftReg), arithmetic shift (floor).
  - The result always lies between old y and x inclusive, so no overflow is possible and no saturation logic is required.
  - shiftReg = 0 gives pass-through (y = x).
  - Rising input: y may stay below x by up to 2^shiftReg - 1.
  - Falling input: y decreases by at least 1 per pass and converges exactly to x.
- inBins[i] is read live in the cycle bin i is updated; there is no snapshot. Upstream must hold inBins stable during busy.
- Bins not yet updated in the current pass keep their previous values. Bins never written since reset remain 0.
- binIndex equals idx while busy, and 0 otherwise.

Optional Feature:
- Macro: BIN_IIR_PEAK_HOLD_EN.
- When defined (fast attack, slow decay):
  - if inBins[i] > outBins[i]: outBins[i] <= inBins[i];
  - else the normal shifted update applies.
- When undefined: the symmetric update above applies in both directions.
- Timing and handshakes are identical in both builds.

Test Plan:
1. Reset; all inBins[i] = 100*i; start with shift=0 -> done only at cycle 121, busy for cycles 1..120, outBins[i] = 100*i, overrun = 0.
2. outBins = 0; inBins all 1000; shift=2; three consecutive passes -> outBins = 250, then 437, then 577.
3. outBins = 1000, inBins = 0, shift=2 -> 750. Separately, y = 1, x = 0, shift=3 -> 0 (since -1 >>> 3 = -1).
4. Second start pulse at cycle 50 of a pass -> ignored; done pulses once at cycle 121; overrun = 1 and stays 1 across later passes.
5. rst asserted asynchronously at cycle 60 of a pass (mid-clock) -> outBins, busy and binIndex go to 0 immediately, with no done pulse. A subsequent start runs a full 120-cycle pass.
6. y = 100, x = 500, shift=4:
   - with BIN_IIR_PEAK_HOLD_EN -> 500; then x = 0 -> 468;
   - without the macro -> 125.
